// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with memory wait counter, stall and illegal-opcode flag.
// Optional BNE dispatch is enabled by defining MCCTRL_BNE_EN.
module multicycle_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [5:0] op,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       branchne,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JEX     = 4'd11;
    localparam logic [3:0] BNEEX   = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branchne;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic       illegal;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctl_t;

    ctl_t       c;
    logic [3:0] st, st_nxt, cnt, cur;
    logic       cnt_last, op_legal, gate;

    assign cnt_last = (cnt == LAST);
    assign gate     = en & ~reset;
    // Outputs look like FETCH while reset is held, even before the reset edge lands.
    assign cur      = reset ? FETCH : st;

    always_comb begin
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
`ifdef MCCTRL_BNE_EN
            OP_BNE:                                    op_legal = 1'b1;
`endif
            default:                                   op_legal = 1'b0;
        endcase
    end

    always_comb begin
        st_nxt = st;
        case (st)
            FETCH:   if (cnt_last) st_nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_R:         st_nxt = EXECUTE;
                    OP_LW, OP_SW: st_nxt = MEMADR;
                    OP_BEQ:       st_nxt = BEQEX;
                    OP_ADDI:      st_nxt = ADDIEX;
                    OP_J:         st_nxt = JEX;
`ifdef MCCTRL_BNE_EN
                    OP_BNE:       st_nxt = BNEEX;
`endif
                    default:      st_nxt = FETCH;
                endcase
            end
            MEMADR:  st_nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (cnt_last) st_nxt = MEMWB;
            MEMWR:   if (cnt_last) st_nxt = FETCH;
            EXECUTE: st_nxt = ALUWB;
            ADDIEX:  st_nxt = ADDIWB;
            default: st_nxt = FETCH;
        endcase
    end

    // Counter only survives a cycle in which the state stays put (the wait states).
    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= FETCH;
            cnt <= 4'd0;
        end else if (en) begin
            st  <= st_nxt;
            cnt <= (st_nxt == st) ? cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        c = '0;
        case (cur)
            FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = cnt_last;
                c.pcwrite = cnt_last;
            end
            DECODE: begin
                c.alusrcb = 2'b11;
                c.illegal = ~op_legal;
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
`ifdef MCCTRL_BNE_EN
            BNEEX: begin
                c.alusrca  = 1'b1;
                c.aluop    = 2'b01;
                c.pcsrc    = 2'b01;
                c.branchne = 1'b1;
            end
`endif
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: ;
        endcase
        // Stall or reset: suppress every side effect, keep the selects.
        if (!gate) begin
            c.irwrite  = 1'b0;
            c.pcwrite  = 1'b0;
            c.memwrite = 1'b0;
            c.regwrite = 1'b0;
            c.branch   = 1'b0;
            c.branchne = 1'b0;
            c.illegal  = 1'b0;
        end
    end

    assign iord     = c.iord;
    assign irwrite  = c.irwrite;
    assign pcwrite  = c.pcwrite;
    assign branch   = c.branch;
    assign branchne = c.branchne;
    assign memwrite = c.memwrite;
    assign regwrite = c.regwrite;
    assign regdst   = c.regdst;
    assign memtoreg = c.memtoreg;
    assign alusrca  = c.alusrca;
    assign alusrcb  = c.alusrcb;
    assign pcsrc    = c.pcsrc;
    assign aluop    = c.aluop;
    assign illegal  = c.illegal;
    assign state    = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction phase-queue model plus literal state sequences.
module tb_multicycle_ctrl;

    localparam int L = 3;

    logic       clk = 1'b0, reset = 1'b1, en = 1'b1;
    logic [5:0] op = 6'd0;
    logic       iord, irwrite, pcwrite, branch, branchne, memwrite, regwrite;
    logic       regdst, memtoreg, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    multicycle_ctrl #(.MEM_LAT(L)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .branchne(branchne), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord, irwrite, pcwrite, branch, branchne, memwrite, regwrite;
        logic       regdst, memtoreg, alusrca, illegal;
        logic [1:0] alusrcb, pcsrc, aluop;
    } ctl_t;

    typedef struct packed {
        logic [3:0] s;
        logic       last;
    } ph_t;

    ph_t        q[$];
    logic [5:0] dir_ops[$];
    int         lit[$];
    bit         enp[$];
    logic [5:0] cur_op;
    bit         cur_ill;
    logic [3:0] last_state;
    logic       last_ill;
    int         pass_cnt = 0, total = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl[7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd5};
        int r;
        if (dir_ops.size() != 0) return dir_ops.pop_front();
        r = $urandom_range(0, 7);
        if (r == 7) return 6'($urandom);
        return tbl[r];
    endfunction

    // Expand one instruction into the sequence of states it must visit.
    function automatic void build(input logic [5:0] o);
        cur_op  = o;
        cur_ill = 1'b0;
        for (int i = 0; i < L; i++) q.push_back('{4'd0, 1'(i == L - 1)});
        q.push_back('{4'd1, 1'b0});
        case (o)
            6'd0:  begin q.push_back('{4'd6, 1'b0}); q.push_back('{4'd7, 1'b0}); end
            6'd35: begin
                q.push_back('{4'd2, 1'b0});
                for (int i = 0; i < L; i++) q.push_back('{4'd3, 1'b0});
                q.push_back('{4'd4, 1'b0});
            end
            6'd43: begin
                q.push_back('{4'd2, 1'b0});
                for (int i = 0; i < L; i++) q.push_back('{4'd5, 1'b0});
            end
            6'd4:  q.push_back('{4'd8, 1'b0});
            6'd8:  begin q.push_back('{4'd9, 1'b0}); q.push_back('{4'd10, 1'b0}); end
            6'd2:  q.push_back('{4'd11, 1'b0});
`ifdef MCCTRL_BNE_EN
            6'd5:  q.push_back('{4'd12, 1'b0});
`endif
            default: cur_ill = 1'b1;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(input ph_t h, input bit e, input bit r, input bit ill);
        ctl_t x = '0;
        logic [3:0] s = r ? 4'd0 : h.s;
        case (s)
            4'd0:  begin x.alusrcb = 2'b01; x.irwrite = h.last; x.pcwrite = h.last; end
            4'd1:  begin x.alusrcb = 2'b11; x.illegal = ill; end
            4'd2:  begin x.alusrca = 1; x.alusrcb = 2'b10; end
            4'd3:  x.iord = 1;
            4'd4:  begin x.memtoreg = 1; x.regwrite = 1; end
            4'd5:  begin x.iord = 1; x.memwrite = 1; end
            4'd6:  begin x.alusrca = 1; x.aluop = 2'b10; end
            4'd7:  begin x.regdst = 1; x.regwrite = 1; end
            4'd8:  begin x.alusrca = 1; x.aluop = 2'b01; x.pcsrc = 2'b01; x.branch = 1; end
            4'd9:  begin x.alusrca = 1; x.alusrcb = 2'b10; end
            4'd10: x.regwrite = 1;
            4'd11: begin x.pcsrc = 2'b10; x.pcwrite = 1; end
            4'd12: begin x.alusrca = 1; x.aluop = 2'b01; x.pcsrc = 2'b01; x.branchne = 1; end
            default: ;
        endcase
        if (r || !e) begin
            x.irwrite = 0; x.pcwrite = 0; x.memwrite = 0; x.regwrite = 0;
            x.branch = 0; x.branchne = 0; x.illegal = 0;
        end
        return x;
    endfunction

    // One clock: drive at negedge, compare 1ns later, advance the model at posedge.
    task automatic step(input bit e, input bit r);
        ph_t  h;
        ctl_t ex, ac;
        @(negedge clk);
        if (!r && q.size() == 0) build(pick_op());
        h = '0;
        if (q.size() != 0) h = q[0];
        en    = e;
        reset = r;
        op    = (!r && (h.s == 4'd1 || h.s == 4'd2)) ? cur_op : 6'($urandom);
        #1;
        ex = expect_ctl(h, e, r, cur_ill);
        ac = {iord, irwrite, pcwrite, branch, branchne, memwrite, regwrite,
              regdst, memtoreg, alusrca, illegal, alusrcb, pcsrc, aluop};
        chk("state", 32'(state), r ? 32'd0 : 32'(h.s));
        chk("ctl", 32'(ac), 32'(ex));
        last_state = state;
        last_ill   = illegal;
        cyc++;
        @(posedge clk);
        if (r) q.delete();
        else if (e && q.size() != 0) void'(q.pop_front());
    endtask

    task automatic run_lit(input string name, input logic [5:0] o);
        dir_ops.push_back(o);
        for (int i = 0; i < lit.size(); i++) begin
            step((i < enp.size()) ? enp[i] : 1'b1, 1'b0);
            chk(name, 32'(last_state), 32'(lit[i]));
        end
        chk({name, "_len"}, 32'(q.size()), 32'd0);
        enp.delete();
    endtask

    initial begin
        step(1, 1);
        step(1, 1);
        chk("rst_state", 32'(last_state), 32'd0);

        lit = '{0, 0, 0, 1, 6, 7};             run_lit("rtype", 6'd0);
        lit = '{0, 0, 0, 1, 2, 3, 3, 3, 4};    run_lit("lw", 6'd35);
        enp = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
        lit = '{0, 0, 0, 1, 2, 5, 5, 5, 5, 5}; run_lit("sw_stall", 6'd43);
        lit = '{0, 0, 0, 1};                   run_lit("illegal", 6'd63);
        chk("ill_flag", 32'(last_ill), 32'd1);
        lit = '{0, 0, 0, 1, 8};                run_lit("beq", 6'd4);
        lit = '{0, 0, 0, 1, 11};               run_lit("j", 6'd2);
        lit = '{0, 0, 0, 1, 9, 10};            run_lit("addi", 6'd8);
`ifdef MCCTRL_BNE_EN
        lit = '{0, 0, 0, 1, 12};               run_lit("bne", 6'd5);
        chk("bne_ill", 32'(last_ill), 32'd0);
`else
        lit = '{0, 0, 0, 1};                   run_lit("bne", 6'd5);
        chk("bne_ill", 32'(last_ill), 32'd1);
`endif

        // Reset in the middle of a load's MEMRD wait.
        lit = '{0, 0, 0, 1, 2, 3};
        dir_ops.push_back(6'd35);
        for (int i = 0; i < lit.size(); i++) begin
            step(1, 0);
            chk("lw_pre_rst", 32'(last_state), 32'(lit[i]));
        end
        step(1, 1);
        chk("rst_memrd", 32'(last_state), 32'd0);
        step(1, 0);
        chk("post_rst", 32'(last_state), 32'd0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 199) == 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
